dmem_load_unit: RTL and testbench
=================================

Name: dmem_load_unit

Overview:
- Read-side companion to the data memory's byte/halfword/word store path.
- Sits in the MEM stage of the 5-stage RISC-V pipeline and executes LB/LH/LW/LBU/LHU against a word-organised memory whose read port has 1-cycle synchronous latency.
- Handles byte-lane extraction and sign/zero extension.
- Splits misaligned accesses that cross a word boundary into two word reads, stalling the pipeline via load_busy until the result is ready.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_req_M  in  1  load request from the MEM stage.
- load_addr_M  in  ADDR_WIDTH  byte address of the load.
- load_type_M  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal.
- load_busy  out  1  high whenever state != IDLE; the pipeline stalls the MEM stage.
- load_valid  out  1  one-cycle pulse, result valid.
- load_data  out  DATA_WIDTH  extended load result; holds its value until the next DONE.
- load_fault  out  1  qualified by load_valid; illegal load_type.
- mem_rd_en  out  1  word read strobe to memory.
- mem_rd_addr  out  ADDR_WIDTH-2  word index (byte address >> 2).
- mem_rd_data  in  DATA_WIDTH  read word, valid the cycle after mem_rd_en.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - load_valid, load_fault, load_data, and the internal address/type/word registers = 0.
  - mem_rd_en = 0.
  - Reset mid-operation aborts the load: no load_valid and no further reads.
- States: IDLE, RD0, RD1, DONE.
- IDLE:
  - A request is accepted when load_req_M=1.
  - Latch the address and type.
  - Legal type: mem_rd_en=1 combinationally in the same cycle, mem_rd_addr=load_addr_M[ADDR_WIDTH-1:2], next state RD0.
  - Illegal type: no read; next state DONE with load_fault=1, load_data=0.
  - load_req_M is ignored in every state other than IDLE; the pipeline must hold its request while load_busy=1.
- RD0:
  - Capture mem_rd_data as w0.
  - Cross-word cases: LW with addr[1:0]!=0, or LH/LHU with addr[1:0]==3.
    - Issue mem_rd_en=1 with mem_rd_addr = latched word index + 1, wrapping modulo 2^(ADDR_WIDTH-2) (0x3FFFFFFF+1 -> 0).
    - Next state RD1.
  - Otherwise: register the result, next state DONE.
- RD1: capture mem_rd_data as w1, register the result, next state DONE.
- DONE:
  - load_valid=1 for exactly one cycle.
  - load_fault = registered fault flag.
  - Next state IDLE.
  - No request is accepted in DONE.
- Result formation:
  - Form the 64-bit value {w1, w0}, with w1=0 when there is no second read.
  - Shift right by 8*addr[1:0].
  - Take the low 8, 16, or 32 bits per type.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - Little-endian byte order.
- Latency from the accept cycle (cycle 0):
  - Aligned/in-word load: load_valid in cycle 2.
  - Cross-word load: load_valid in cycle 3.
  - Illegal type: load_valid in cycle 1.
  - Back-to-back throughput is one load every 3 or 4 cycles.
- load_busy = (state != IDLE), driven combinationally from state.
- mem_rd_en is never asserted outside IDLE-accept or RD0-split; at most 2 reads per load.

Decomposition:
- Shared package contents:
  - load type constants (LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101).
  - state encoding (IDLE, RD0, RD1, DONE).
  - a function for the cross-word predicate.
- Sub-module load_align_ext: purely combinational.
  - Inputs: w0, w1, addr[1:0], type.
  - Output: extended 32-bit result.
  - Reused by the bench reference model.

Test Plan:
- Aligned loads, word4=0x8899AABB: LW 0x10 -> 0x8899AABB, exactly one read of word 4, load_valid at cycle 2, load_busy high in cycles 1-2.
- Sub-word loads from word4:
  - LB 0x13 -> 0xFFFFFF88; LBU 0x13 -> 0x00000088.
  - LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899.
  - LB 0x10 -> 0xFFFFFFBB.
- Cross-word loads, word5=0x11223344:
  - LW 0x11 -> 0x448899AA; LH 0x13 -> 0x00004488.
  - Both read words 4 then 5 on consecutive cycles, load_valid at cycle 3.
- Wrap-around: LW 0xFFFFFFFE with word 0x3FFFFFFF=0xDEAD0000 and word0=0x0000BEEF -> reads word 0x3FFFFFFF then word 0, result 0xBEEFDEAD.
- Illegal load_type 3'b011 -> no mem_rd_en, load_valid=1 and load_fault=1 at cycle 1, load_data=0. A following LW completes normally with load_fault=0.
- Reset and request handling:
  - Pulse rst_n low during RD1 -> state IDLE immediately, load_valid never pulses, all outputs 0.
  - load_req_M held during busy is not re-accepted (exactly one load_valid per accepted request).

Source files
------------

// File: rtl/dmem_load_unit_pkg.sv
// Shared definitions for the data-memory load unit.
// Contents: load type (funct3) encodings, FSM state encoding, and helper
// functions that classify a load as legal and as crossing a word boundary.
package dmem_load_unit_pkg;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD0  = 2'd1,
    ST_RD1  = 2'd2,
    ST_DONE = 2'd3
  } load_state_e;

  function automatic logic is_legal_type(input logic [2:0] ltype);
    return (ltype == LT_LB) || (ltype == LT_LH) || (ltype == LT_LW) ||
           (ltype == LT_LBU) || (ltype == LT_LHU);
  endfunction

  // A load needs a second word when its bytes run past byte 3 of the word.
  function automatic logic is_cross_word(input logic [2:0] ltype,
                                         input logic [1:0] addr_lo);
    return ((ltype == LT_LW) && (addr_lo != 2'd0)) ||
           (((ltype == LT_LH) || (ltype == LT_LHU)) && (addr_lo == 2'd3));
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Byte-lane extraction and sign/zero extension for loads.
// Ports:
//   i_w0      : first (lower-address) memory word
//   i_w1      : second memory word, zero when the load fits in one word
//   i_addr_lo : byte offset of the load within the first word
//   i_type    : funct3 load type
//   o_result  : extended 32-bit load result (zero for illegal types)
module load_align_ext
  import dmem_load_unit_pkg::*;
(
  input  logic [31:0] i_w0,
  input  logic [31:0] i_w1,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_type,
  output logic [31:0] o_result
);

  logic [31:0] w_sel;

  // Little-endian: shifting {w1,w0} right by the byte offset puts the
  // addressed byte in lane 0, with following bytes spilling in from w1.
  assign w_sel = 32'(({i_w1, i_w0}) >> {i_addr_lo, 3'b000});

  always_comb begin
    o_result = '0;
    case (i_type)
      LT_LB:   o_result = {{24{w_sel[7]}}, w_sel[7:0]};
      LT_LH:   o_result = {{16{w_sel[15]}}, w_sel[15:0]};
      LT_LW:   o_result = w_sel;
      LT_LBU:  o_result = {24'd0, w_sel[7:0]};
      LT_LHU:  o_result = {16'd0, w_sel[15:0]};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_load_unit.sv
// MEM-stage load unit for LB/LH/LW/LBU/LHU against a word-organised memory
// with a 1-cycle synchronous read port. Loads that cross a word boundary are
// split into two consecutive word reads; the pipeline is stalled meanwhile.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   load_req_M    : load request (sampled only in IDLE; must be held while busy)
//   load_addr_M   : byte address
//   load_type_M   : funct3 load type
//   load_busy     : high whenever the FSM is not IDLE
//   load_valid    : one-cycle result strobe (DONE state)
//   load_data     : extended result, held until the next DONE
//   load_fault    : illegal load type, qualified by load_valid
//   mem_rd_en     : word read strobe
//   mem_rd_addr   : word index of the read
//   mem_rd_data   : read word, valid the cycle after mem_rd_en
//   o_dbg_state   : current FSM state
// Handshake: a request is taken on the rising edge where the FSM is IDLE and
// load_req_M=1; the requester then holds its inputs until load_busy falls.
module dmem_load_unit
  import dmem_load_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_req_M,
  input  logic [ADDR_WIDTH-1:0] load_addr_M,
  input  logic [2:0]            load_type_M,
  output logic                  load_busy,
  output logic                  load_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_fault,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-3:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [1:0]            o_dbg_state
);

  localparam int WW = ADDR_WIDTH - 2;

  load_state_e           r_state, w_state_n;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_type;
  logic [DATA_WIDTH-1:0] r_w0;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_fault;

  logic                  w_legal;
  logic                  w_cross;
  logic [31:0]           w_align_w0;
  logic [31:0]           w_align_w1;
  logic [31:0]           w_result;

  assign w_legal = is_legal_type(load_type_M);
  assign w_cross = is_cross_word(r_type, r_addr[1:0]);

  // In RD0 the first word arrives directly from memory; in RD1 it comes
  // from r_w0 and the second word arrives from memory.
  assign w_align_w0 = (r_state == ST_RD1) ? r_w0 : mem_rd_data;
  assign w_align_w1 = (r_state == ST_RD1) ? mem_rd_data : 32'd0;

  load_align_ext u_align (
    .i_w0      (w_align_w0),
    .i_w1      (w_align_w1),
    .i_addr_lo (r_addr[1:0]),
    .i_type    (r_type),
    .o_result  (w_result)
  );

  always_comb begin
    w_state_n   = r_state;
    mem_rd_en   = 1'b0;
    mem_rd_addr = r_addr[ADDR_WIDTH-1:2];
    case (r_state)
      ST_IDLE: begin
        if (load_req_M) begin
          if (w_legal) begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = load_addr_M[ADDR_WIDTH-1:2];
            w_state_n   = ST_RD0;
          end else begin
            w_state_n   = ST_DONE;
          end
        end
      end
      ST_RD0: begin
        if (w_cross) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = r_addr[ADDR_WIDTH-1:2] + WW'(1);
          w_state_n   = ST_RD1;
        end else begin
          w_state_n   = ST_DONE;
        end
      end
      ST_RD1:  w_state_n = ST_DONE;
      ST_DONE: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_type  <= '0;
      r_w0    <= '0;
      r_data  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_n;
      case (r_state)
        ST_IDLE: begin
          if (load_req_M) begin
            r_addr  <= load_addr_M;
            r_type  <= load_type_M;
            r_fault <= !w_legal;
            if (!w_legal) r_data <= '0;
          end
        end
        ST_RD0: begin
          r_w0 <= mem_rd_data;
          if (!w_cross) r_data <= w_result;
        end
        ST_RD1:  r_data <= w_result;
        default: ;
      endcase
    end
  end

  assign load_busy   = (r_state != ST_IDLE);
  assign load_valid  = (r_state == ST_DONE);
  assign load_fault  = (r_state == ST_DONE) && r_fault;
  assign load_data   = r_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_load_unit.sv
module tb_dmem_load_unit;

  logic        clk;
  logic        rst_n;
  logic        load_req_M;
  logic [31:0] load_addr_M;
  logic [2:0]  load_type_M;
  logic        load_busy;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_fault;
  logic        mem_rd_en;
  logic [29:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_g    = 0;
  int valid_cnt = 0;

  logic [29:0] exp_q[$];   // expected word reads of the current load
  logic [29:0] rd_q[$];    // observed word reads
  int          rd_cyc_q[$];

  dmem_load_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_req_M  (load_req_M),
    .load_addr_M (load_addr_M),
    .load_type_M (load_type_M),
    .load_busy   (load_busy),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_fault  (load_fault),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [29:0] w);
    case (w)
      30'h0000_0004: return 32'h8899_AABB;
      30'h0000_0005: return 32'h1122_3344;
      30'h3FFF_FFFF: return 32'hDEAD_0000;
      30'h0000_0000: return 32'h0000_BEEF;
      default:       return {2'b00, w} ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc_g <= cyc_g + 1;
    if (load_valid) valid_cnt <= valid_cnt + 1;
    if (mem_rd_en) begin
      mem_rd_data <= mem_word(mem_rd_addr);
      rd_q.push_back(mem_rd_addr);
      rd_cyc_q.push_back(cyc_g);
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one load, holds the request until the result strobe, then checks
  // latency, data, fault, busy profile and the word reads against exp_q.
  task automatic run_load(input string tag, input logic [31:0] a, input logic [2:0] t,
                          input logic [31:0] exp_d, input logic exp_f, input int exp_lat);
    int lat;
    int v0;
    logic got;
    rd_q.delete();
    rd_cyc_q.delete();
    @(negedge clk);
    load_req_M  = 1'b1;
    load_addr_M = a;
    load_type_M = t;
    #1;
    check({tag, ":busy_c0"}, 32'(load_busy), 32'd0);
    v0  = valid_cnt;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (load_valid) got = 1'b1;
      else check({tag, ":busy"}, 32'(load_busy), 32'd1);
    end
    load_req_M = 1'b0;
    check({tag, ":valid_seen"}, 32'(got), 32'd1);
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ":busy_done"}, 32'(load_busy), 32'd1);
    check({tag, ":data"}, load_data, exp_d);
    check({tag, ":fault"}, 32'(load_fault), 32'(exp_f));
    repeat (4) @(negedge clk);
    check({tag, ":idle"}, 32'(load_busy), 32'd0);
    check({tag, ":data_hold"}, load_data, exp_d);
    check({tag, ":valid_pulses"}, 32'(valid_cnt - v0), 32'd1);
    check({tag, ":n_reads"}, 32'(rd_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++)
      check($sformatf("%s:rd_addr%0d", tag, i), 32'(rd_q[i]), 32'(exp_q[i]));
    if (exp_q.size() == 2 && rd_q.size() == 2)
      check({tag, ":rd_back_to_back"}, 32'(rd_cyc_q[1] - rd_cyc_q[0]), 32'd1);
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int v0;
    rst_n       = 1'b0;
    load_req_M  = 1'b0;
    load_addr_M = '0;
    load_type_M = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst:busy",  32'(load_busy),  32'd0);
    check("rst:valid", 32'(load_valid), 32'd0);
    check("rst:fault", 32'(load_fault), 32'd0);
    check("rst:data",  load_data,       32'd0);
    check("rst:rd_en", 32'(mem_rd_en),  32'd0);
    check("rst:state", 32'(dbg_state),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned and in-word loads from word 4 = 0x8899AABB.
    exp_q.push_back(30'h4); run_load("lw_10",  32'h10, 3'b010, 32'h8899_AABB, 1'b0, 2);
    exp_q.push_back(30'h4); run_load("lb_13",  32'h13, 3'b000, 32'hFFFF_FF88, 1'b0, 2);
    exp_q.push_back(30'h4); run_load("lbu_13", 32'h13, 3'b100, 32'h0000_0088, 1'b0, 2);
    exp_q.push_back(30'h4); run_load("lh_12",  32'h12, 3'b001, 32'hFFFF_8899, 1'b0, 2);
    exp_q.push_back(30'h4); run_load("lhu_12", 32'h12, 3'b101, 32'h0000_8899, 1'b0, 2);
    exp_q.push_back(30'h4); run_load("lb_10",  32'h10, 3'b000, 32'hFFFF_FFBB, 1'b0, 2);

    // Cross-word loads spanning words 4 and 5.
    exp_q.push_back(30'h4); exp_q.push_back(30'h5);
    run_load("lw_11", 32'h11, 3'b010, 32'h4488_99AA, 1'b0, 3);
    exp_q.push_back(30'h4); exp_q.push_back(30'h5);
    run_load("lh_13", 32'h13, 3'b001, 32'h0000_4488, 1'b0, 3);

    // Word index wraps from the top of memory to word 0.
    exp_q.push_back(30'h3FFF_FFFF); exp_q.push_back(30'h0);
    run_load("lw_wrap", 32'hFFFF_FFFE, 3'b010, 32'hBEEF_DEAD, 1'b0, 3);

    // Illegal type: no reads, fault with zero data; next load is clean.
    run_load("illegal_011", 32'h10, 3'b011, 32'h0000_0000, 1'b1, 1);
    exp_q.push_back(30'h5); run_load("lw_14_after", 32'h14, 3'b010, 32'h1122_3344, 1'b0, 2);

    // Reset during RD1 of a cross-word load aborts it.
    rd_q.delete();
    @(negedge clk);
    load_req_M  = 1'b1;
    load_addr_M = 32'h11;
    load_type_M = 3'b010;
    v0 = valid_cnt;
    repeat (2) @(negedge clk);
    load_req_M = 1'b0;
    check("rstmid:in_rd1", 32'(dbg_state), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rstmid:busy",  32'(load_busy),  32'd0);
    check("rstmid:valid", 32'(load_valid), 32'd0);
    check("rstmid:data",  load_data,       32'd0);
    check("rstmid:fault", 32'(load_fault), 32'd0);
    check("rstmid:rd_en", 32'(mem_rd_en),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rstmid:no_valid", 32'(valid_cnt - v0), 32'd0);
    check("rstmid:n_reads", 32'(rd_q.size()), 32'd2);
    check("rstmid:idle", 32'(load_busy), 32'd0);

    // After recovery a load works normally (request held through busy above).
    exp_q.push_back(30'h4); run_load("lhu_10_post", 32'h10, 3'b101, 32'h0000_AABB, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
